// File: rtl/multi_counter_display_if.sv
// ---------------------------------------------------------------------------
// multi_counter_display_if
// Bundles the per-channel counter controls and the 7-segment display outputs
// of multi_counter_display.
//   inc/dec/clr  : per-channel single-cycle pulses
//   mode_dec     : per-channel radix, 1 = BCD, 0 = hex
//   ch_sel       : manual channel choice, auto_scan : rotate channels
//   anode        : active-low digit enables, cathode : active-low A..G, DP
//   ch_shown     : channel currently on the display
//   overflow     : sticky per-channel limit flags
// master drives the controls, slave is the counter/display block.
// ---------------------------------------------------------------------------
interface multi_counter_display_if #(
    parameter int NUM_CH = 4,
    parameter int DIGITS = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] dec;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] mode_dec;
    logic [CH_W-1:0]   ch_sel;
    logic              auto_scan;
    logic [DIGITS-1:0] anode;
    logic [7:0]        cathode;
    logic [CH_W-1:0]   ch_shown;
    logic [NUM_CH-1:0] overflow;

    modport master (
        output inc, dec, clr, mode_dec, ch_sel, auto_scan,
        input  anode, cathode, ch_shown, overflow
    );

    modport slave (
        input  inc, dec, clr, mode_dec, ch_sel, auto_scan,
        output anode, cathode, ch_shown, overflow
    );
endinterface

// File: rtl/multi_counter_display.sv
// ---------------------------------------------------------------------------
// multi_counter_display
// NUM_CH independent up/down counters (hex or BCD, DIGITS nibbles each) with
// a multiplexed active-low 7-segment display of one selected channel.
// Ports:
//   clk        : system clock
//   CPU_RESETN : asynchronous active-low reset (release synchronised here)
//   bus        : multi_counter_display_if.slave (controls in, display out)
// ---------------------------------------------------------------------------
module multi_counter_display #(
    parameter int NUM_CH    = 4,
    parameter int DIGITS    = 4,
    parameter int CLK_PER   = 10,
    parameter int REFR_RATE = 1000,
    parameter int DWELL_CYC = 200_000_000,
    parameter int WRAP      = 1
) (
    input  logic clk,
    input  logic CPU_RESETN,
    multi_counter_display_if.slave bus
);
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W    = 4 * DIGITS;
    localparam int SCAN_RAW = 1_000_000_000 / (CLK_PER * REFR_RATE * DIGITS);
    localparam int SCAN_CYC = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
    localparam int SCAN_W   = $clog2(SCAN_CYC + 1);
    localparam int DWELL_W  = $clog2(DWELL_CYC + 1);

    localparam logic [VAL_W-1:0] HEX_MAX = '1;
    localparam logic [VAL_W-1:0] DEC_MAX = {DIGITS{4'h9}};

    // BCD +1: ripple the carry through nibbles that roll 9 -> 0
    function automatic logic [VAL_W-1:0] bcd_inc(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0] r;
        logic             c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1: ripple the borrow through nibbles that roll 0 -> 9
    function automatic logic [VAL_W-1:0] bcd_dec(input logic [VAL_W-1:0] v);
        logic [VAL_W-1:0] r;
        logic             b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_font(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Reset asserts immediately, releases two clocks after CPU_RESETN rises
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) r_rst_sync <= 2'b00;
        else             r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // Channel counters
    logic [VAL_W-1:0]  r_val [NUM_CH];
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] r_mode_q;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int n = 0; n < NUM_CH; n++) r_val[n] <= '0;
            r_ovf    <= '0;
            r_mode_q <= '0;
        end else begin
            r_mode_q <= bus.mode_dec;
            for (int n = 0; n < NUM_CH; n++) begin
                if (bus.clr[n]) begin
                    r_val[n] <= '0;
                    r_ovf[n] <= 1'b0;
                end else if (bus.mode_dec[n] != r_mode_q[n]) begin
                    // radix switch: old contents are meaningless in the new radix
                    r_val[n] <= '0;
                end else if (bus.inc[n] && bus.dec[n]) begin
                    r_val[n] <= r_val[n];
                end else if (bus.inc[n]) begin
                    if (r_val[n] == (bus.mode_dec[n] ? DEC_MAX : HEX_MAX)) begin
                        r_val[n] <= (WRAP != 0) ? '0
                                    : (bus.mode_dec[n] ? DEC_MAX : HEX_MAX);
                        r_ovf[n] <= 1'b1;
                    end else begin
                        r_val[n] <= bus.mode_dec[n] ? bcd_inc(r_val[n])
                                                    : r_val[n] + VAL_W'(1);
                    end
                end else if (bus.dec[n]) begin
                    if (r_val[n] == '0) begin
                        if (WRAP != 0) begin
                            r_val[n] <= bus.mode_dec[n] ? DEC_MAX : HEX_MAX;
                            r_ovf[n] <= 1'b1;
                        end
                    end else begin
                        r_val[n] <= bus.mode_dec[n] ? bcd_dec(r_val[n])
                                                    : r_val[n] - VAL_W'(1);
                    end
                end
            end
        end
    end

    // Digit scan timer; r_adv_q delays the display load one clock past the advance
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DIG_W-1:0]  r_digit;
    logic              r_adv_q;
    logic              w_scan_tc;

    assign w_scan_tc = (r_scan_cnt == '0);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_adv_q    <= 1'b0;
        end else begin
            r_adv_q <= w_scan_tc;
            if (w_scan_tc) begin
                r_scan_cnt <= SCAN_W'(SCAN_CYC - 1);
                r_digit    <= (r_digit == DIG_W'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt - 1'b1;
            end
        end
    end

    // Channel selection: manual (registered ch_sel) or timed rotation
    logic [DWELL_W-1:0] r_dwell;
    logic [CH_W-1:0]    r_ch_shown;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dwell    <= '0;
            r_ch_shown <= '0;
        end else if (!bus.auto_scan) begin
            r_dwell    <= '0;
            r_ch_shown <= (int'(bus.ch_sel) >= NUM_CH) ? '0 : bus.ch_sel;
        end else if (r_dwell == DWELL_W'(DWELL_CYC - 1)) begin
            r_dwell    <= '0;
            r_ch_shown <= (r_ch_shown == CH_W'(NUM_CH - 1)) ? '0 : r_ch_shown + 1'b1;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    // Segment pattern for the current digit of the shown channel
    logic [VAL_W-1:0] w_cur;
    logic [DIG_W-1:0] w_msd;
    logic [3:0]       w_nib;
    logic [7:0]       w_seg;

    assign w_cur = r_val[r_ch_shown];

    always_comb begin
        w_msd = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_cur[4*d +: 4] != 4'd0) w_msd = DIG_W'(d);
        end
        w_nib = w_cur[{r_digit, 2'b00} +: 4];
        w_seg = (r_digit > w_msd) ? 8'hFF : seg_font(w_nib);
        // decimal point flags overflow, on digit 0 only
        w_seg[7] = ~((r_digit == '0) && r_ovf[r_ch_shown]);
    end

    logic [DIGITS-1:0] r_anode;
    logic [7:0]        r_cathode;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_anode   <= '1;
            r_cathode <= 8'hFF;
        end else if (r_adv_q) begin
            r_anode   <= ~(DIGITS'(1) << r_digit);
            r_cathode <= w_seg;
        end
    end

    assign bus.anode    = r_anode;
    assign bus.cathode  = r_cathode;
    assign bus.ch_shown = r_ch_shown;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_multi_counter_display.sv
// ---------------------------------------------------------------------------
// tb_multi_counter_display
// Two instances share one stimulus stream: u_dut wraps at the limits,
// u_dut_sat saturates. A numeric model predicts channel values; expected
// segment patterns are queued when a display read is requested and popped
// as each digit is strobed by the DUT.
// ---------------------------------------------------------------------------
module tb_multi_counter_display;
    localparam int NUM_CH    = 4;
    localparam int DIGITS    = 4;
    localparam int CLK_PER   = 10;
    localparam int REFR_RATE = 5_000_000;   // five clocks per digit
    localparam int DWELL_CYC = 100;
    localparam int CH_W      = 2;

    localparam logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #(CLK_PER/2) clk = ~clk;

    multi_counter_display_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS)) if_w ();
    multi_counter_display_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS)) if_s ();

    assign if_s.inc       = if_w.inc;
    assign if_s.dec       = if_w.dec;
    assign if_s.clr       = if_w.clr;
    assign if_s.mode_dec  = if_w.mode_dec;
    assign if_s.ch_sel    = if_w.ch_sel;
    assign if_s.auto_scan = if_w.auto_scan;

    multi_counter_display #(
        .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CLK_PER(CLK_PER),
        .REFR_RATE(REFR_RATE), .DWELL_CYC(DWELL_CYC), .WRAP(1)
    ) u_dut (
        .clk(clk), .CPU_RESETN(rst_n), .bus(if_w.slave)
    );

    multi_counter_display #(
        .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CLK_PER(CLK_PER),
        .REFR_RATE(REFR_RATE), .DWELL_CYC(DWELL_CYC), .WRAP(0)
    ) u_dut_sat (
        .clk(clk), .CPU_RESETN(rst_n), .bus(if_s.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Model: index 0 = wrapping instance, 1 = saturating instance
    int mval [2][NUM_CH];
    bit movf [2][NUM_CH];
    bit mmode [NUM_CH];
    logic [7:0] sb_q [$];

    function automatic int vmax(input bit dm);
        return dm ? (10**DIGITS) - 1 : (16**DIGITS) - 1;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < NUM_CH; c++) begin
                mval[w][c] = 0;
                movf[w][c] = 1'b0;
            end
    endtask

    task automatic model_step(input logic [3:0] i, input logic [3:0] d, input logic [3:0] c);
        for (int w = 0; w < 2; w++)
            for (int ch = 0; ch < NUM_CH; ch++) begin
                int mx;
                mx = vmax(mmode[ch]);
                if (c[ch]) begin
                    mval[w][ch] = 0;
                    movf[w][ch] = 1'b0;
                end else if (i[ch] && d[ch]) begin
                    mval[w][ch] = mval[w][ch];
                end else if (i[ch]) begin
                    if (mval[w][ch] == mx) begin
                        mval[w][ch] = (w == 0) ? 0 : mx;
                        movf[w][ch] = 1'b1;
                    end else begin
                        mval[w][ch]++;
                    end
                end else if (d[ch]) begin
                    if (mval[w][ch] == 0) begin
                        if (w == 0) begin
                            mval[w][ch] = mx;
                            movf[w][ch] = 1'b1;
                        end
                    end else begin
                        mval[w][ch]--;
                    end
                end
            end
    endtask

    function automatic logic [7:0] exp_seg(input int w, input int ch, input int d);
        int base, v, p, msd, nib;
        logic [7:0] s;
        base = mmode[ch] ? 10 : 16;
        v = mval[w][ch];
        p = 1;
        msd = 0;
        nib = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if ((v / p) % base != 0) msd = k;
            if (k == d) nib = (v / p) % base;
            p = p * base;
        end
        s = (d > msd) ? 8'hFF : FONT[nib];
        if (d == 0 && movf[w][ch]) s[7] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] get_an(input int w);
        return (w != 0) ? if_s.anode : if_w.anode;
    endfunction

    function automatic logic [7:0] get_ca(input int w);
        return (w != 0) ? if_s.cathode : if_w.cathode;
    endfunction

    // Hold the given pulse masks for n clocks (n counts), then release
    task automatic drive(input logic [3:0] i, input logic [3:0] d, input logic [3:0] c, input int n);
        if_w.inc = i;
        if_w.dec = d;
        if_w.clr = c;
        for (int k = 0; k < n; k++) model_step(i, d, c);
        repeat (n) @(posedge clk);
        #1;
        if_w.inc = '0;
        if_w.dec = '0;
        if_w.clr = '0;
    endtask

    task automatic set_mode(input int ch, input bit m);
        if (mmode[ch] != m)
            for (int w = 0; w < 2; w++) mval[w][ch] = 0;
        mmode[ch] = m;
        if_w.mode_dec[ch] = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Select a channel, sync to digit 0 of a fresh rotation and compare every digit
    task automatic check_disp(input int w, input int ch, input string tag);
        int t;
        logic [3:0] prev;
        logic [3:0] ea;
        if_w.auto_scan = 1'b0;
        if_w.ch_sel = CH_W'(ch);
        repeat (3) @(posedge clk);
        @(negedge clk);
        t = 0;
        while (get_an(w) !== 4'b0111 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_sync"}, get_an(w), 4'b0111);
        for (int d = 0; d < DIGITS; d++) sb_q.push_back(exp_seg(w, ch, d));
        for (int d = 0; d < DIGITS; d++) begin
            prev = get_an(w);
            t = 0;
            while (get_an(w) === prev && t < 50) begin
                @(negedge clk);
                t++;
            end
            ea = ~(4'd1 << d);
            chk($sformatf("%s_an%0d", tag, d), get_an(w), ea);
            chk($sformatf("%s_seg%0d", tag, d), get_ca(w), sb_q.pop_front());
        end
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        if_w.inc = '0;
        if_w.dec = '0;
        if_w.clr = '0;
        if_w.mode_dec = '0;
        if_w.ch_sel = '0;
        if_w.auto_scan = 1'b0;
        for (int c = 0; c < NUM_CH; c++) mmode[c] = 1'b0;
        model_reset();

        // reset state, with pulses that must be ignored
        if_w.inc = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_anode", if_w.anode, 4'hF);
        chk("rst_cathode", if_w.cathode, 8'hFF);
        chk("rst_ch_shown", if_w.ch_shown, 0);
        chk("rst_overflow", if_w.overflow, 0);
        if_w.inc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_disp(0, 0, "post_rst");

        // hex wrap instance
        drive(4'b0001, 4'b0000, 4'b0000, 4095);
        check_disp(0, 0, "hex_0fff");
        drive(4'b0001, 4'b0000, 4'b0000, 1);
        check_disp(0, 0, "hex_1000");
        drive(4'b0000, 4'b0000, 4'b0001, 1);
        drive(4'b0000, 4'b0001, 4'b0000, 1);
        chk("ovf_hex_dec0", if_w.overflow[0], 1'b1);
        chk("sat_ovf_dec0", if_s.overflow[0], 1'b0);
        check_disp(0, 0, "hex_ffff");
        check_disp(1, 0, "sat_dec0");
        drive(4'b0001, 4'b0000, 4'b0000, 1);
        chk("ovf_hex_wrap", if_w.overflow[0], 1'b1);
        check_disp(0, 0, "hex_wrap");

        // BCD on channel 1
        set_mode(1, 1'b1);
        drive(4'b0010, 4'b0000, 4'b0000, 10);
        check_disp(0, 1, "dec_10");
        drive(4'b0000, 4'b0000, 4'b0010, 1);
        drive(4'b0000, 4'b0010, 4'b0000, 1);
        chk("ovf_dec_wrap", if_w.overflow[1], 1'b1);
        chk("sat_ovf_dec_dec0", if_s.overflow[1], 1'b0);
        check_disp(0, 1, "dec_9999");
        check_disp(1, 1, "sat_dec_dec0");
        drive(4'b0010, 4'b0010, 4'b0000, 1);
        check_disp(0, 1, "inc_dec");
        drive(4'b0010, 4'b0000, 4'b0010, 1);
        chk("clr_inc_ovf", if_w.overflow[1], 1'b0);
        check_disp(0, 1, "clr_inc");

        // radix change clears the value, overflow untouched
        drive(4'b0100, 4'b0000, 4'b0000, 171);
        check_disp(0, 2, "hex_ab");
        set_mode(2, 1'b1);
        check_disp(0, 2, "mode_clr");
        drive(4'b0100, 4'b0000, 4'b0000, 1);
        check_disp(0, 2, "mode_inc");

        // saturation at the BCD maximum on channel 3
        set_mode(3, 1'b1);
        drive(4'b1000, 4'b0000, 4'b0000, 9999);
        drive(4'b1000, 4'b0000, 4'b0000, 1);
        chk("sat_ovf_max", if_s.overflow[3], 1'b1);
        chk("wrap_ovf_max", if_w.overflow[3], 1'b1);
        check_disp(1, 3, "sat_max");
        check_disp(0, 3, "wrap_max");

        // reset in the middle of counting with the display active
        drive(4'b0000, 4'b0000, 4'b0001, 1);
        drive(4'b0001, 4'b0000, 4'b0000, 291);
        check_disp(0, 0, "pre_rst_123");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_anode", if_w.anode, 4'hF);
        chk("midrst_cathode", if_w.cathode, 8'hFF);
        chk("midrst_sat_anode", if_s.anode, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_ovf", if_w.overflow, 0);
        for (int c = 0; c < NUM_CH; c++) check_disp(0, c, $sformatf("midrst_ch%0d", c));

        // channel rotation
        if_w.ch_sel = '0;
        if_w.auto_scan = 1'b0;
        @(posedge clk);
        #1;
        chk("dwell_start", if_w.ch_shown, 0);
        if_w.auto_scan = 1'b1;
        repeat (DWELL_CYC - 1) @(posedge clk);
        #1;
        chk("dwell_edge", if_w.ch_shown, 0);
        @(posedge clk);
        #1;
        chk("dwell_1", if_w.ch_shown, 1);
        for (int k = 2; k <= 4; k++) begin
            repeat (DWELL_CYC) @(posedge clk);
            #1;
            chk($sformatf("dwell_%0d", k), if_w.ch_shown, k % NUM_CH);
        end
        if_w.auto_scan = 1'b0;
        if_w.ch_sel = 2'd2;
        @(posedge clk);
        #1;
        chk("manual_sel", if_w.ch_shown, 2);
        chk("manual_sel_sat", if_s.ch_shown, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_counter_display.md
MULTI_COUNTER_DISPLAY -- requirements
Module: multi_counter_display

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent counter channels (1..16).
REQ-002 SHALL have parameter DIGITS, default 4: nibble digits per channel and 7-segment digits driven (1..8).
REQ-003 SHALL have parameter CLK_PER, default 10: clock period in ns.
REQ-004 SHALL have parameter REFR_RATE, default 1000: full-display refresh rate in Hz; digit advance period SCAN_CYC = 1e9/(CLK_PER*REFR_RATE*DIGITS) clocks, minimum 1.
REQ-005 SHALL have parameter DWELL_CYC, default 200_000_000: clocks per channel in auto-scan mode.
REQ-006 SHALL have parameter WRAP, default 1: 1 = wrap at limits, 0 = saturate.
REQ-007 SHALL have ports: clk input 1 system clock; CPU_RESETN input 1 asynchronous active-low reset.
REQ-008 SHALL have ports: inc, dec, clr input [NUM_CH] single-cycle per-channel pulses (already debounced); mode_dec input [NUM_CH], 1 = DEC, 0 = HEX.
REQ-009 SHALL have ports: ch_sel input [$clog2(NUM_CH)] manual channel; auto_scan input 1 enable channel rotation.
REQ-010 SHALL have ports: anode output [DIGITS-1:0] active-low digit enables; cathode output [7:0] active-low, bit0=A..bit6=G, bit7=DP.
REQ-011 SHALL have ports: ch_shown output [$clog2(NUM_CH)] channel on display; overflow output [NUM_CH] sticky per-channel limit flag.

Function
REQ-012 Each channel SHALL hold DIGITS nibbles; HEX: binary count mod 16^DIGITS; DEC: BCD, each nibble 0-9, carry/borrow per digit, max 10^DIGITS-1.
REQ-013 Per-channel priority per cycle SHALL be: clr (value 0, overflow cleared) > inc&dec together (no change) > inc (+1) > dec (-1); update visible next cycle.
REQ-014 inc at max: WRAP=1 -> 0 and overflow set; WRAP=0 -> hold max, overflow set.
REQ-015 dec at 0: WRAP=1 -> max and overflow set; WRAP=0 -> hold 0, overflow unchanged.
REQ-016 A change of mode_dec[n] (detected against a registered copy) SHALL clear channel n value to 0 in the following cycle; overflow unchanged.
REQ-017 Scan timer SHALL count SCAN_CYC clocks; on terminal count digit index advances d -> d+1, DIGITS-1 -> 0.
REQ-018 anode SHALL drive only bit d low; anode and cathode SHALL be registered and update one clock after the digit advance.
REQ-019 cathode SHALL use standard hex font (0xC0 '0', 0xF9 '1', 0xA4 '2', 0xB0 '3', 0x99 '4', 0x92 '5', 0x82 '6', 0xF8 '7', 0x80 '8', 0x90 '9', 0x88 'A', 0x83 'b', 0xC6 'C', 0xA1 'd', 0x86 'E', 0x8E 'F').
REQ-020 Leading-zero blanking: digits above the most significant nonzero digit SHALL output cathode 0xFF; digit 0 always shown.
REQ-021 DP (bit7) SHALL be lit (0) only on digit 0 when overflow[ch_shown]=1.
REQ-022 auto_scan=0: ch_shown SHALL equal ch_sel registered one cycle; ch_sel >= NUM_CH selects 0.
REQ-023 auto_scan=1: dwell counter SHALL advance ch_shown every DWELL_CYC clocks, NUM_CH-1 -> 0; dwell counter cleared whenever auto_scan=0.
REQ-024 Channel change SHALL not reset the scan timer or digit index; new channel data appears at the next digit advance.

Reset
REQ-025 CPU_RESETN low SHALL asynchronously force: all values 0, overflow 0, anode all 1s, cathode 0xFF, digit index 0, scan and dwell counters 0, ch_shown 0.
REQ-026 Reset release SHALL be synchronised internally (2-flop); first anode enable occurs at the first scan terminal count after release.
REQ-027 Pulses on inc/dec/clr during reset SHALL be ignored.

Verification
REQ-028 Reset mid-count (ch0=0x0123, display active): CPU_RESETN=0 -> same timestep anode=0xF, cathode=0xFF; after release all channels read 0.
REQ-029 HEX ch0, WRAP=1: value 0x0FFF + inc -> 0x1000; 0xFFFF + inc -> 0x0000, overflow[0]=1, digit0 cathode 0x40.
REQ-030 DEC ch1 from 0: 10 incs -> BCD 0x0010; displayed digit0 0xC0, digit1 0xF9, digits 2-3 0xFF.
REQ-031 dec at 0: WRAP=0 -> stays 0, overflow 0; WRAP=1 DEC -> 0x9999, overflow=1; inc+dec same cycle -> unchanged; clr+inc -> 0.
REQ-032 Mode toggle ch2 HEX 0x00AB -> DEC: next cycle value 0; subsequent inc -> 0x0001.
REQ-033 NUM_CH=4, DWELL_CYC=100, auto_scan=1: ch_shown 0,1,2,3,0 at 100-clock intervals; auto_scan=0, ch_sel=2 -> ch_shown=2 one cycle later.
